ex_redirect_ctrl: RTL and testbench
===================================

Name: ex_redirect_ctrl

Overview:
- Execute-stage control-flow sequencer for the RV32IC pipeline.
- Takes taken-branch/jump resolution from the EX stage and issues a single redirect request to fetch with a valid/ack handshake.
- Squashes wrong-path instructions reaching EX until the instruction at the redirect target arrives.
- Replaces ad-hoc stall-PC tracking inside the ALU with one explicit FSM.

Parameters:
- XLEN, 32, datapath/PC width.
- TIMEOUT, 64, max cycles in WAIT before abandoning the target match (range 2..65535).
- CNT_W, 16, width of the optional performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_ex_valid  in  1  EX stage holds a valid instruction.
- i_stall  in  1  downstream stall; EX instruction does not advance.
- i_ex_pc  in  XLEN  PC of the instruction in EX.
- i_ex_redirect  in  1  EX instruction is a taken branch, JAL or JALR.
- i_ex_target  in  XLEN  resolved target of that instruction.
- i_redirect_ack  in  1  fetch accepts the redirect this cycle.
- o_redirect_valid  out  1  redirect request to fetch.
- o_redirect_pc  out  XLEN  redirect target.
- o_ex_kill  out  1  squash the EX instruction (no RegWrite/MemWrite), combinational.
- o_busy  out  1  FSM not in RUN.
- o_err  out  1  sticky: timeout or misaligned target.
- o_redir_cnt  out  CNT_W  redirects issued (optional feature).
- o_squash_cnt  out  CNT_W  instructions squashed (optional feature).

Behaviour:
- Definition: adv = i_ex_valid & ~i_stall & ~o_ex_kill.
- Reset (i_reset=0, async): state=RUN; o_redirect_valid=0; o_redirect_pc=0; o_err=0; wait counter=0; perf counters=0. This applies mid-operation as well: any pending request is dropped.
- RUN: o_ex_kill=0. On adv & i_ex_redirect:
  - latch i_ex_target into o_redirect_pc;
  - next cycle o_redirect_valid=1 and state=REQ (1-cycle latency).
- Misaligned target: if i_ex_target[0]=1, set o_err, latch the target with bit0 forced to 0, and proceed normally.
- REQ:
  - o_redirect_valid=1, held stable (pc unchanged) until i_redirect_ack.
  - o_ex_kill = i_ex_valid.
  - On i_redirect_ack: o_redirect_valid=0 next cycle, state=WAIT, wait counter cleared.
- WAIT:
  - o_ex_kill = i_ex_valid & (i_ex_pc != o_redirect_pc).
  - On i_ex_valid & i_ex_pc==o_redirect_pc: that instruction is not killed. State=RUN next cycle.
  - If that target instruction is itself adv & i_ex_redirect, latch its target and go directly to REQ instead of RUN (back-to-back redirect).
  - Wait counter increments every WAIT cycle, including stalled ones. On reaching TIMEOUT-1 with no match: o_err=1, state=RUN.
- i_stall: o_ex_kill is still driven for the held instruction. Squash counting only occurs when ~i_stall.
- i_ex_redirect on a killed instruction is ignored.
- o_busy = (state != RUN).
- Clearing o_err requires reset.

Optional Feature:
- Macro: EX_REDIRECT_PERF_EN.
- Defined:
  - o_redir_cnt increments on each RUN/WAIT->REQ transition.
  - o_squash_cnt increments on each cycle with i_ex_valid & o_ex_kill & ~i_stall.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both outputs tied to 0; no counter flops are generated.

Test Plan:
- Reset mid-REQ (state REQ, o_redirect_valid=1, assert i_reset=0) -> o_redirect_valid=0, o_busy=0, o_err=0 immediately, without waiting for a clock.
- Redirect, immediate ack, target arrives 2 cycles later:
  - stimulus: adv, i_ex_redirect=1, i_ex_target=0x100; ack 1 cycle later; PCs 0x24, 0x28 killed, then 0x100.
  - response: o_redirect_valid high exactly 1 cycle with pc=0x100; 0x100 not killed; o_busy low the following cycle.
- Ack delayed 3 cycles (target 0x200) -> o_redirect_valid and pc=0x200 held stable for 4 cycles; every valid EX instruction killed meanwhile.
- Back-to-back redirect:
  - stimulus: target 0x100 arrives with i_ex_redirect=1, i_ex_target=0x300.
  - response: 0x100 not killed; next cycle o_redirect_valid=1, pc=0x300.
- Timeout: TIMEOUT=8, WAIT with target never matching -> o_err=1 and state RUN after 8 WAIT cycles; kills stop.
- Misalign/perf (EX_REDIRECT_PERF_EN defined):
  - stimulus: target 0x101, then 3 wrong-path instructions.
  - response: o_err=1, o_redirect_pc=0x100, o_redir_cnt=1, o_squash_cnt=3.

Source files
------------

// File: rtl/ex_redirect_ctrl.sv
// Execute-stage redirect sequencer: issues one fetch redirect per taken branch/jump and
// squashes wrong-path instructions until the target arrives. Optional counters: EX_REDIRECT_PERF_EN.
module ex_redirect_ctrl #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ex_valid,
   input  logic             i_stall,
   input  logic [XLEN-1:0]  i_ex_pc,
   input  logic             i_ex_redirect,
   input  logic [XLEN-1:0]  i_ex_target,
   input  logic             i_redirect_ack,
   output logic             o_redirect_valid,
   output logic [XLEN-1:0]  o_redirect_pc,
   output logic             o_ex_kill,
   output logic             o_busy,
   output logic             o_err,
   output logic [CNT_W-1:0] o_redir_cnt,
   output logic [CNT_W-1:0] o_squash_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam int WCNT_W = 16;
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

   state_t            state;
   logic [WCNT_W-1:0] wait_cnt;
   logic              kill;
   logic              adv;
   logic              take;
   logic              target_hit;
   logic              timeout_hit;
   logic [XLEN-1:0]   aligned_target;

   always_comb begin
      kill = 1'b0;
      case (state)
         REQ:     kill = i_ex_valid;
         WAIT:    kill = i_ex_valid & (i_ex_pc != o_redirect_pc);
         default: kill = 1'b0;
      endcase
   end

   // A killed instruction never advances, so its redirect can never be taken.
   assign adv            = i_ex_valid & ~i_stall & ~kill;
   assign take           = adv & i_ex_redirect;
   assign target_hit     = i_ex_valid & (i_ex_pc == o_redirect_pc);
   assign timeout_hit    = (state == WAIT) & ~target_hit & (wait_cnt == WAIT_LAST);
   assign aligned_target = {i_ex_target[XLEN-1:1], 1'b0};

   assign o_ex_kill = kill;
   assign o_busy    = (state != RUN);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state            <= RUN;
         o_redirect_valid <= 1'b0;
         o_redirect_pc    <= '0;
         o_err            <= 1'b0;
         wait_cnt         <= '0;
      end else begin
         if (take && i_ex_target[0]) o_err <= 1'b1;
         if (timeout_hit)             o_err <= 1'b1;
         case (state)
            RUN: begin
               if (take) begin
                  o_redirect_pc    <= aligned_target;
                  o_redirect_valid <= 1'b1;
                  state            <= REQ;
               end
            end
            REQ: begin
               if (i_redirect_ack) begin
                  o_redirect_valid <= 1'b0;
                  wait_cnt         <= '0;
                  state            <= WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // The target instruction may itself redirect: chain straight into REQ.
               if (target_hit) begin
                  if (take) begin
                     o_redirect_pc    <= aligned_target;
                     o_redirect_valid <= 1'b1;
                     state            <= REQ;
                  end else begin
                     state <= RUN;
                  end
               end else if (timeout_hit) begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

`ifdef EX_REDIRECT_PERF_EN
   logic [CNT_W-1:0] redir_cnt;
   logic [CNT_W-1:0] squash_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         redir_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         if (take)                          redir_cnt  <= sat_inc(redir_cnt);
         if (i_ex_valid && kill && !i_stall) squash_cnt <= sat_inc(squash_cnt);
      end
   end

   assign o_redir_cnt  = redir_cnt;
   assign o_squash_cnt = squash_cnt;
`else
   assign o_redir_cnt  = '0;
   assign o_squash_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Directed vector bench for ex_redirect_ctrl (TIMEOUT=8); counter expectations follow EX_REDIRECT_PERF_EN.
module tb_ex_redirect_ctrl;

   localparam int XLEN  = 32;
   localparam int CNT_W = 16;
`ifdef EX_REDIRECT_PERF_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ex_valid, stall, ex_redirect, redirect_ack;
   logic [XLEN-1:0]  ex_pc, ex_target;
   logic             redirect_valid, ex_kill, busy, err;
   logic [XLEN-1:0]  redirect_pc;
   logic [CNT_W-1:0] redir_cnt, squash_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   ex_redirect_ctrl #(.XLEN(XLEN), .TIMEOUT(8), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_ex_valid(ex_valid), .i_stall(stall),
      .i_ex_pc(ex_pc), .i_ex_redirect(ex_redirect), .i_ex_target(ex_target),
      .i_redirect_ack(redirect_ack), .o_redirect_valid(redirect_valid),
      .o_redirect_pc(redirect_pc), .o_ex_kill(ex_kill), .o_busy(busy), .o_err(err),
      .o_redir_cnt(redir_cnt), .o_squash_cnt(squash_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        st;
      logic [31:0] pc;
      logic        rd;
      logic [31:0] tg;
      logic        ack;
      logic        e_rv;
      logic [31:0] e_rpc;
      logic        e_kill;
      logic        e_busy;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic st, input logic [31:0] pc, input logic rd,
                      input logic [31:0] tg, input logic ack, input logic e_rv,
                      input logic [31:0] e_rpc, input logic e_kill, input logic e_busy,
                      input logic e_err);
      vec_t t;
      t.v = v; t.st = st; t.pc = pc; t.rd = rd; t.tg = tg; t.ack = ack;
      t.e_rv = e_rv; t.e_rpc = e_rpc; t.e_kill = e_kill; t.e_busy = e_busy; t.e_err = e_err;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic v, input logic st, input logic [31:0] pc, input logic rd,
                        input logic [31:0] tg, input logic ack);
      ex_valid = v; stall = st; ex_pc = pc; ex_redirect = rd; ex_target = tg; redirect_ack = ack;
   endtask

   task automatic do_reset();
      apply(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      apply(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("reset rv", redirect_valid, 0);
      check("reset pc", redirect_pc, 0);
      check("reset busy", busy, 0);
      check("reset err", err, 0);
      check("reset redir_cnt", redir_cnt, 0);
      check("reset squash_cnt", squash_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      //   v  st pc      rd tg      ack | rv rpc     kill busy err
      add(1, 0, 'h020, 1, 'h100, 0,   0, 'h000, 0, 0, 0);  // take redirect to 0x100
      add(1, 0, 'h024, 0, 'h000, 1,   1, 'h100, 1, 1, 0);  // REQ, immediate ack
      add(1, 0, 'h028, 0, 'h000, 0,   0, 'h100, 1, 1, 0);  // WAIT, wrong path
      add(1, 0, 'h100, 0, 'h000, 0,   0, 'h100, 0, 1, 0);  // target arrives
      add(1, 0, 'h104, 0, 'h000, 0,   0, 'h100, 0, 0, 0);  // back in RUN
      add(1, 0, 'h108, 1, 'h200, 0,   0, 'h100, 0, 0, 0);  // redirect to 0x200
      add(1, 0, 'h10c, 0, 'h000, 0,   1, 'h200, 1, 1, 0);  // REQ held 1
      add(1, 0, 'h110, 1, 'h500, 0,   1, 'h200, 1, 1, 0);  // REQ held 2, killed redirect ignored
      add(0, 0, 'h114, 0, 'h000, 0,   1, 'h200, 0, 1, 0);  // REQ held 3, bubble not killed
      add(1, 0, 'h114, 0, 'h000, 1,   1, 'h200, 1, 1, 0);  // REQ held 4, ack
      add(1, 0, 'h200, 1, 'h300, 0,   0, 'h200, 0, 1, 0);  // target redirects again
      add(1, 0, 'h204, 0, 'h000, 1,   1, 'h300, 1, 1, 0);  // back-to-back REQ, ack
      add(1, 1, 'h208, 0, 'h000, 0,   0, 'h300, 1, 1, 0);  // stalled wrong path still killed
      add(1, 1, 'h300, 1, 'h700, 0,   0, 'h300, 0, 1, 0);  // stalled target matches
      add(1, 0, 'h300, 0, 'h000, 0,   0, 'h300, 0, 0, 0);  // RUN, no stray redirect
      add(1, 0, 'h304, 1, 'h400, 0,   0, 'h300, 0, 0, 0);  // redirect to 0x400
      add(1, 0, 'h308, 0, 'h000, 1,   1, 'h400, 1, 1, 0);  // ack -> WAIT
      for (int k = 0; k < 8; k++)
         add(1, 0, 'h500, 0, 'h000, 0, 0, 'h400, 1, 1, 0); // 8 WAIT cycles, never matches
      add(1, 0, 'h504, 0, 'h000, 0,   0, 'h400, 0, 0, 1);  // timed out: RUN, err, no kill

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].v, vecs[i].st, vecs[i].pc, vecs[i].rd, vecs[i].tg, vecs[i].ack);
         #1;
         check($sformatf("v%0d rv", i),   redirect_valid, vecs[i].e_rv);
         check($sformatf("v%0d rpc", i),  redirect_pc,    vecs[i].e_rpc);
         check($sformatf("v%0d kill", i), ex_kill,        vecs[i].e_kill);
         check($sformatf("v%0d busy", i), busy,           vecs[i].e_busy);
         check($sformatf("v%0d err", i),  err,            vecs[i].e_err);
         @(negedge clk);
      end

      // Misaligned target followed by three squashed wrong-path instructions.
      do_reset();
      check("post-reset err", err, 0);
      apply(1, 0, 'h040, 1, 'h101, 0);
      @(negedge clk);
      check("mis err", err, 1);
      check("mis rpc", redirect_pc, 'h100);
      check("mis rv", redirect_valid, 1);
      apply(1, 0, 'h044, 0, 0, 1);
      #1 check("mis kill 0x44", ex_kill, 1);
      @(negedge clk);
      apply(1, 0, 'h048, 0, 0, 0);
      #1 check("mis kill 0x48", ex_kill, 1);
      @(negedge clk);
      apply(1, 0, 'h04c, 0, 0, 0);
      #1 check("mis kill 0x4c", ex_kill, 1);
      @(negedge clk);
      apply(1, 0, 'h100, 0, 0, 0);
      #1 check("mis kill 0x100", ex_kill, 0);
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0);
      #1;
      check("mis busy", busy, 0);
      check("mis err held", err, 1);
      check("mis rpc held", redirect_pc, 'h100);
      check("redir_cnt", redir_cnt, PERF ? 1 : 0);
      check("squash_cnt", squash_cnt, PERF ? 3 : 0);

      // Asynchronous reset while a request is pending.
      apply(1, 0, 'h104, 1, 'h600, 0);
      @(negedge clk);
      apply(0, 0, 0, 0, 0, 0);
      #1;
      check("pre-reset rv", redirect_valid, 1);
      check("pre-reset busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async rst rv", redirect_valid, 0);
      check("async rst busy", busy, 0);
      check("async rst err", err, 0);
      check("async rst pc", redirect_pc, 0);
      check("async rst redir_cnt", redir_cnt, 0);
      check("async rst squash_cnt", squash_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("after rst busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
